// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch / load-store request, response and data-bank signals for
//            mem_port_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              if_rsp_err;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [2:0]        ls_funct3;
    logic              ls_rsp_valid;
    logic [31:0]       ls_rsp_data;
    logic              ls_rsp_err;

    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_read_data;

    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_we, ls_addr, ls_wdata, ls_funct3,
        input  mem_read_data,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        output mem_read_en, mem_write_en, mem_address, mem_write_data, mem_funct3
    );

    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_we, ls_addr, ls_wdata, ls_funct3,
        output mem_read_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        input  mem_read_en, mem_write_en, mem_address, mem_write_data, mem_funct3
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single-ported RV32I data bank between fetch and the
//            LSU; screens illegal accesses. Option macro: MEM_ARB_RR_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCESS  = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;
    localparam logic [2:0] c_F3_WORD = 3'b010;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_can_grant;
    logic              w_ls_wins;
    logic              w_grant_ls;
    logic              w_grant_if;
    logic              w_if_err;
    logic              w_ld_err;
    logic              w_st_err;
    logic              w_ls_err;

    logic              r_is_ls;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic [31:0]       r_rsp_data;

    logic              w_mem_read_en;
    logic              w_mem_write_en;
    logic              w_if_rsp_valid;
    logic              w_ls_rsp_valid;

    assign w_can_grant = !rst && ((r_state == c_IDLE) || (r_state == c_RESP));

`ifdef MEM_ARB_RR_EN
    logic r_last_ls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ls <= 1'b0;
        end else if (w_grant_ls) begin
            r_last_ls <= 1'b1;
        end else if (w_grant_if) begin
            r_last_ls <= 1'b0;
        end
    end

    // On a tie the side that did not win last time takes the bank.
    assign w_ls_wins = bus.ls_req_valid && (!bus.if_req_valid || !r_last_ls);
`else
    assign w_ls_wins = bus.ls_req_valid;
`endif

    assign w_grant_ls = w_can_grant && w_ls_wins;
    assign w_grant_if = w_can_grant && bus.if_req_valid && !w_ls_wins;

    always_comb begin
        w_if_err = |bus.if_addr[1:0];
        w_ld_err = 1'b0;
        w_st_err = 1'b0;
        case (bus.ls_funct3)
            3'b000, 3'b100: w_ld_err = 1'b0;
            3'b001, 3'b101: w_ld_err = bus.ls_addr[0];
            3'b010:         w_ld_err = |bus.ls_addr[1:0];
            default:        w_ld_err = 1'b1;
        endcase
        case (bus.ls_funct3)
            3'b000:  w_st_err = 1'b0;
            3'b001:  w_st_err = bus.ls_addr[0];
            3'b010:  w_st_err = |bus.ls_addr[1:0];
            default: w_st_err = 1'b1;
        endcase
        w_ls_err = bus.ls_we ? w_st_err : w_ld_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   w_next_state = (w_grant_ls || w_grant_if) ? c_ACCESS : c_IDLE;
            c_ACCESS: w_next_state = c_RESP;
            c_RESP:   w_next_state = (w_grant_ls || w_grant_if) ? c_ACCESS : c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_ls    <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_grant_ls) begin
                r_is_ls  <= 1'b1;
                r_we     <= bus.ls_we;
                r_err    <= w_ls_err;
                r_addr   <= bus.ls_addr;
                r_wdata  <= bus.ls_wdata;
                r_funct3 <= bus.ls_funct3;
            end else if (w_grant_if) begin
                r_is_ls  <= 1'b0;
                r_we     <= 1'b0;
                r_err    <= w_if_err;
                r_addr   <= bus.if_addr;
                r_funct3 <= c_F3_WORD;
            end
            // Stores and screened accesses return zero data.
            if (r_state == c_ACCESS) begin
                r_rsp_data <= (r_err || r_we) ? 32'd0 : bus.mem_read_data;
            end
        end
    end

    always_comb begin
        w_mem_read_en  = 1'b0;
        w_mem_write_en = 1'b0;
        w_if_rsp_valid = 1'b0;
        w_ls_rsp_valid = 1'b0;
        if (!rst) begin
            if (r_state == c_ACCESS && !r_err) begin
                w_mem_read_en  = !r_we;
                w_mem_write_en = r_we;
            end
            if (r_state == c_RESP) begin
                w_ls_rsp_valid = r_is_ls;
                w_if_rsp_valid = !r_is_ls;
            end
        end
    end

    assign bus.if_req_ready   = w_grant_if;
    assign bus.ls_req_ready   = w_grant_ls;
    assign bus.if_rsp_valid   = w_if_rsp_valid;
    assign bus.ls_rsp_valid   = w_ls_rsp_valid;
    assign bus.if_rsp_data    = r_rsp_data;
    assign bus.ls_rsp_data    = r_rsp_data;
    assign bus.if_rsp_err     = w_if_rsp_valid && r_err;
    assign bus.ls_rsp_err     = w_ls_rsp_valid && r_err;
    assign bus.mem_read_en    = w_mem_read_en;
    assign bus.mem_write_en   = w_mem_write_en;
    assign bus.mem_address    = r_addr;
    assign bus.mem_write_data = r_wdata;
    assign bus.mem_funct3     = r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter with a byte bank.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_init = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_ren = 0;
    int   n_wen = 0;

    logic [32:0] ls_q[$];
    logic [32:0] if_q[$];
    logic [7:0]  mem [0:63];

    mem_port_arbiter_if #(.ADDR_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed data bank: combinational read, write at clock edge.
    logic [5:0]  a0, a1, a2, a3;
    logic [31:0] rd;
    always_comb begin
        a0 = bus.mem_address[5:0];
        a1 = a0 + 6'd1;
        a2 = a0 + 6'd2;
        a3 = a0 + 6'd3;
        case (bus.mem_funct3)
            3'b000:  rd = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  rd = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b100:  rd = {24'd0, mem[a0]};
            3'b101:  rd = {16'd0, mem[a1], mem[a0]};
            default: rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
        bus.mem_read_data = rd;
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hDD; mem[1] <= 8'hCC; mem[2] <= 8'hBB; mem[3] <= 8'hAA;
        end else if (bus.mem_write_en) begin
            mem[a0] <= bus.mem_write_data[7:0];
            if (bus.mem_funct3[1:0] != 2'b00) mem[a1] <= bus.mem_write_data[15:8];
            if (bus.mem_funct3[1:0] == 2'b10) begin
                mem[a2] <= bus.mem_write_data[23:16];
                mem[a3] <= bus.mem_write_data[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response appears.
    logic [32:0] e_ls, e_if;
    always @(negedge clk) begin
        if (bus.mem_read_en)  n_ren++;
        if (bus.mem_write_en) n_wen++;
        if (bus.ls_rsp_valid && bus.if_rsp_valid) begin
            n_vec++; n_err++;
            $display("FAIL dual_rsp: both rsp_valid high, required at most one");
        end
        if (bus.ls_rsp_valid) begin
            if (ls_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL ls_unexpected_rsp: got data %h, required no response", bus.ls_rsp_data);
            end else begin
                e_ls = ls_q.pop_front();
                chk("ls_rsp_data", bus.ls_rsp_data, e_ls[31:0]);
                chk("ls_rsp_err", {31'd0, bus.ls_rsp_err}, {31'd0, e_ls[32]});
            end
        end
        if (bus.if_rsp_valid) begin
            if (if_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL if_unexpected_rsp: got data %h, required no response", bus.if_rsp_data);
            end else begin
                e_if = if_q.pop_front();
                chk("if_rsp_data", bus.if_rsp_data, e_if[31:0]);
                chk("if_rsp_err", {31'd0, bus.if_rsp_err}, {31'd0, e_if[32]});
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_ready", {30'd0, bus.ls_req_ready, bus.if_req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.ls_rsp_valid, bus.if_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {30'd0, bus.ls_rsp_err, bus.if_rsp_err}, 32'd0);
        chk("rst_enables", {30'd0, bus.mem_read_en, bus.mem_write_en}, 32'd0);
        chk("rst_rsp_data", bus.ls_rsp_data | bus.if_rsp_data, 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        chk("rst_mem_funct3", {29'd0, bus.mem_funct3}, 32'd0);
    endtask

    // Issue one request, check the ACCESS cycle and response latency.
    task automatic issue(input bit is_ls, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_d, input bit exp_e);
        bit got = 0;
        @(negedge clk);
        if (is_ls) begin
            bus.ls_we = we; bus.ls_addr = addr; bus.ls_wdata = wdata;
            bus.ls_funct3 = f3; bus.ls_req_valid = 1'b1;
        end else begin
            bus.if_addr = addr; bus.if_req_valid = 1'b1;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (is_ls ? bus.ls_req_ready : bus.if_req_ready) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL grant_timeout: addr %h never granted", addr);
            bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
            return;
        end
        if (is_ls) ls_q.push_back({exp_e, exp_d});
        else       if_q.push_back({exp_e, exp_d});
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
        chk("access_read_en", {31'd0, bus.mem_read_en}, {31'd0, !exp_e && !we});
        chk("access_write_en", {31'd0, bus.mem_write_en}, {31'd0, !exp_e && we});
        if (!exp_e) begin
            chk("access_address", bus.mem_address, addr);
            chk("access_funct3", {29'd0, bus.mem_funct3}, {29'd0, is_ls ? f3 : 3'b010});
        end
        @(posedge clk); #1;
        chk("rsp_latency", {31'd0, is_ls ? bus.ls_rsp_valid : bus.if_rsp_valid}, 32'd1);
    endtask

    initial begin
        int ren0, en0, n_l, n_f;
        bit alt_ok, prev_ls, lr, fr;
        bus.if_req_valid = 1'b0; bus.if_addr = '0;
        bus.ls_req_valid = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_wdata = '0; bus.ls_funct3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; tb_init = 1'b0;
        chk_reset_state();

        // Load word, one read strobe
        ren0 = n_ren;
        issue(1, 0, 32'h0, 32'h0, 3'b010, 32'hAABBCCDD, 0);
        @(negedge clk);
        chk("lw_read_en_cycles", n_ren - ren0, 1);

        // Store byte then load it back, plus signed/unsigned narrow loads
        issue(1, 1, 32'h5, 32'h0000007F, 3'b000, 32'h0, 0);
        issue(1, 0, 32'h5, 32'h0, 3'b100, 32'h0000007F, 0);
        issue(1, 0, 32'h3, 32'h0, 3'b000, 32'hFFFFFFAA, 0);
        issue(1, 0, 32'h2, 32'h0, 3'b001, 32'hFFFFAABB, 0);
        issue(1, 0, 32'h2, 32'h0, 3'b101, 32'h0000AABB, 0);
        issue(0, 0, 32'h0, 32'h0, 3'b010, 32'hAABBCCDD, 0);
        issue(1, 1, 32'hC, 32'h11223344, 3'b010, 32'h0, 0);
        issue(1, 0, 32'hE, 32'h0, 3'b101, 32'h00001122, 0);

        // Misaligned and illegal accesses: no strobes, err with zero data
        repeat (3) @(negedge clk);
        en0 = n_ren + n_wen;
        issue(1, 0, 32'h2, 32'h0, 3'b010, 32'h0, 1);
        issue(1, 1, 32'h3, 32'h1234, 3'b001, 32'h0, 1);
        issue(0, 0, 32'h6, 32'h0, 3'b010, 32'h0, 1);
        issue(1, 0, 32'h0, 32'h0, 3'b011, 32'h0, 1);
        issue(1, 1, 32'h0, 32'h0, 3'b100, 32'h0, 1);
        @(negedge clk);
        chk("err_no_enables", n_ren + n_wen - en0, 0);

        // Contention: both requesters valid for 8 cycles from IDLE
        repeat (3) @(negedge clk);
        @(negedge clk);
        bus.ls_we = 1'b0; bus.ls_addr = 32'h0; bus.ls_funct3 = 3'b010; bus.if_addr = 32'h0;
        bus.ls_req_valid = 1'b1; bus.if_req_valid = 1'b1;
        n_l = 0; n_f = 0; alt_ok = 1; prev_ls = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            lr = bus.ls_req_ready; fr = bus.if_req_ready;
            chk("one_ready", {31'd0, lr && fr}, 32'd0);
            if (lr || fr) begin
                if ((n_l + n_f) > 0 && prev_ls == lr) alt_ok = 0;
                prev_ls = lr;
            end
            if (lr) begin n_l++; ls_q.push_back({1'b0, 32'hAABBCCDD}); end
            if (fr) begin n_f++; if_q.push_back({1'b0, 32'hAABBCCDD}); end
        end
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("rr_ls_grants", n_l, 2);
        chk("rr_if_grants", n_f, 2);
        chk("rr_alternate", {31'd0, alt_ok}, 32'd1);
`else
        chk("fixed_ls_grants", n_l, 4);
        chk("fixed_if_grants", n_f, 0);
`endif
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a store word
        @(negedge clk);
        bus.ls_we = 1'b1; bus.ls_addr = 32'h8; bus.ls_wdata = 32'hCAFEF00D;
        bus.ls_funct3 = 3'b010; bus.ls_req_valid = 1'b1;
        #1 chk("sw_ready", {31'd0, bus.ls_req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_access_write_en", {31'd0, bus.mem_write_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state();
        repeat (4) @(negedge clk);
        issue(1, 0, 32'h8, 32'h0, 3'b010, 32'h0, 0);

        repeat (5) @(negedge clk);
        chk("ls_q_drained", ls_q.size(), 0);
        chk("if_q_drained", if_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported RV32I data memory bank. It shares the bank between the instruction-fetch unit (read-only, word) and the load/store unit (LB/LH/LW/LBU/LHU/SB/SH/SW). It screens misaligned and illegal accesses, drives the bank's read_en/write_en/address/funct3 for one access cycle, and returns a registered response to the granted requester.

## Interface
- ADDR_W, 32, byte-address width passed to memory
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  fetch misaligned
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted this cycle
- ls_we  in  1  1=store, 0=load
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data
- ls_funct3  in  3  RV32I LOAD/STORE funct3
- ls_rsp_valid  out  1  load/store response pulse (loads and stores)
- ls_rsp_data  out  32  load result (0 for stores and errors)
- ls_rsp_err  out  1  misaligned or illegal funct3
- mem_read_en, mem_write_en  out  1 each  bank enables
- mem_address  out  ADDR_W  bank address
- mem_write_data  out  32  bank store data
- mem_funct3  out  3  bank size/sign select
- mem_read_data  in  32  bank combinational read result

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Grant possible in IDLE and RESP. Handshake: req_ready is asserted combinationally only when the FSM can grant and that requester wins. A transfer occurs on a cycle with valid&&ready. The request fields are latched at that edge. Requesters hold valid and fields stable until ready.
- Default arbitration: load/store has fixed priority over fetch. Only one ready is asserted per cycle.
- Legality check is performed at grant and latched as an err flag.
  - Fetch error: if_addr[1:0]!=0.
  - Load error: funct3 in {011,110,111}; LH/LHU with addr[0]=1; LW with addr[1:0]!=0.
  - Store error: funct3 >010; SH with addr[0]=1; SW with addr[1:0]!=0.
- ACCESS, no error:
  - mem_address, mem_funct3 (fetch forces 010) and mem_write_data are driven from latches.
  - mem_read_en=!we and mem_write_en=we, for exactly one cycle.
  - mem_read_data is captured into the response register at the end of the cycle.
- ACCESS with error: both enables stay 0; response data is 0 and err=1.
- RESP: the granted side's rsp_valid=1 for one cycle, with data/err. The next state is ACCESS if a new grant occurs, else IDLE.
- Enables are 0 in every state except ACCESS. mem_address, mem_write_data and mem_funct3 hold their last latched values.

## Timing
- Grant at edge N. ACCESS occupies cycle N+1. rsp_valid in cycle N+2. Load latency is 2 cycles and store latency is 2 cycles; the store is committed by the bank at the end of N+1.
- Maximum throughput: one access per 2 cycles, with back-to-back grants taken during RESP.
- Simultaneous valid from both requesters: the winner is granted. The loser's valid stays pending and is granted at the next grant opportunity if it then wins.
- Reset values: state=IDLE; all ready, rsp_valid, rsp_err and enables 0; rsp_data, mem_address, mem_write_data and mem_funct3 are 0.
- Reset mid-operation: the transaction is dropped and no rsp_valid is produced. If rst coincides with ACCESS, mem_write_en is forced 0 in that cycle.
- rsp_valid is never asserted for both requesters in the same cycle.

## Configuration
- MEM_ARB_RR_EN
  - Defined: round-robin priority. A last_grant register (reset = fetch) gives priority to the requester not granted most recently. Ties alternate, so the loading LSU cannot starve fetch.
  - Undefined: fixed load/store priority, and no last_grant register.

## Test plan
- Load word: ls valid, we=0, funct3=010, addr=0x0; bank returns 0xAABBCCDD. Required: ls_rsp_valid 2 cycles after grant, data 0xAABBCCDD, err=0, mem_read_en high exactly one cycle.
- Store byte then load byte: SB addr=0x5 wdata=0x7F, then LBU addr=0x5. Required: mem_write_en one cycle with mem_funct3=000, mem_address=0x5; the subsequent load response is 0x0000007F.
- Misaligned: LW addr=0x2, SH addr=0x3, fetch addr=0x6. Required: each rsp has err=1 and data 0, and no enable is asserted.
- Contention: both valid continuously for 8 cycles.
  - Without macro: only ls granted, and fetch starves.
  - With MEM_ARB_RR_EN: grants alternate fetch, ls, fetch, ls.
- Reset: assert rst during an ACCESS cycle of SW addr=0x8. Required: mem_write_en=0 that cycle, no rsp_valid afterward, and all outputs at reset values next cycle.
